// File: rtl/sap_loader_pkg.sv
// rtl/sap_loader_pkg.sv - shared state encoding and constants for the SAP program loader
package sap_loader_pkg;

  typedef enum logic [3:0] {
    S_CLEAR,
    S_IDLE,
    S_ADDR_H,
    S_ADDR_L,
    S_CNT_H,
    S_CNT_L,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERROR
  } state_t;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

  // ADDR_H, ADDR_L, CNT_H, CNT_L
  localparam int HDR_LEN = 4;

endpackage

// File: rtl/sap_word_packer.sv
// rtl/sap_word_packer.sv - assembles MSB-first bytes into DATA_W-bit words
module sap_word_packer #(
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_valid,
  output logic [DATA_W-1:0] o_word,
  output logic              o_word_valid
);

  localparam int         BYTES    = DATA_W / 8;
  localparam logic [3:0] LAST_IDX = 4'(BYTES - 1);

  logic [3:0] r_idx;

  // The word is complete when the byte that lands in the last slot is accepted;
  // o_word already includes that byte so the caller can register it directly.
  assign o_word_valid = i_byte_valid && !i_clear && (r_idx == LAST_IDX);

  // Byte-index counter; restarts whenever the caller is not inside a data run
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_idx <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
    end else if (i_byte_valid) begin
      r_idx <= (r_idx == LAST_IDX) ? 4'd0 : r_idx + 4'd1;
    end
  end

  if (BYTES == 1) begin : g_single
    assign o_word = i_byte;
  end else begin : g_multi
    logic [DATA_W-9:0] r_shift;

    assign o_word = {r_shift, i_byte};

    // Shift earlier bytes up so the first byte of a word ends in the top lane
    always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
        r_shift <= '0;
      end else if (i_byte_valid && !i_clear) begin
        r_shift <= o_word[DATA_W-9:0];
      end
    end
  end

endmodule

// File: rtl/sap_prog_loader.sv
// rtl/sap_prog_loader.sv - framed byte-stream loader that writes SAP RAM and gates CPU reset
module sap_prog_loader
  import sap_loader_pkg::*;
#(
  parameter int         DATA_W         = 16,
  parameter int         ADDR_W         = 8,
  parameter int         CLEAR_ON_RESET = 1,
  parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_err
);

  state_t            r_state;
  logic              r_in_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_cpu_hold;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_cnt;
  logic [7:0]        r_hdr_h;
  logic [7:0]        r_sum;
  logic [ADDR_W-1:0] r_clr_cnt;

  logic              w_acc;
  logic [15:0]       w_hdr16;
  logic [DATA_W-1:0] w_word;
  logic              w_word_valid;

  assign w_acc   = i_in_valid && r_in_ready;
  assign w_hdr16 = {r_hdr_h, i_in_data};

  assign o_in_ready  = r_in_ready;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_cpu_hold  = r_cpu_hold;
  assign o_done      = r_done;
  assign o_err       = r_err;

  sap_word_packer #(
    .DATA_W(DATA_W)
  ) u_packer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (r_state != S_DATA),
    .i_byte      (i_in_data),
    .i_byte_valid(w_acc),
    .o_word      (w_word),
    .o_word_valid(w_word_valid)
  );

  // Loader FSM: clear sweep, frame parsing, checksum and CPU hold control
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_hold  <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_hdr_h     <= '0;
      r_sum       <= '0;
      r_clr_cnt   <= '0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= r_clr_cnt;
          r_mem_wdata <= '0;
          r_clr_cnt   <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == '1) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
          end
        end
        S_IDLE, S_RUN, S_ERROR: begin
          r_in_ready <= 1'b1;
          if (w_acc && (i_in_data == SYNC_BYTE)) begin
            r_state    <= S_ADDR_H;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_sum      <= '0;
          end
        end
        S_ADDR_H: if (w_acc) begin
          r_hdr_h <= i_in_data;
          r_sum   <= r_sum + i_in_data;
          r_state <= S_ADDR_L;
        end
        S_ADDR_L: if (w_acc) begin
          r_addr  <= w_hdr16[ADDR_W-1:0];
          r_sum   <= r_sum + i_in_data;
          r_state <= S_CNT_H;
        end
        S_CNT_H: if (w_acc) begin
          r_hdr_h <= i_in_data;
          r_sum   <= r_sum + i_in_data;
          r_state <= S_CNT_L;
        end
        S_CNT_L: if (w_acc) begin
          r_cnt   <= w_hdr16;
          r_sum   <= r_sum + i_in_data;
          r_state <= (w_hdr16 == 16'd0) ? S_CSUM : S_DATA;
        end
        S_DATA: if (w_acc) begin
          r_sum <= r_sum + i_in_data;
          if (w_word_valid) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= w_word;
            r_addr      <= r_addr + 1'b1;
            r_cnt       <= r_cnt - 16'd1;
            if (r_cnt == 16'd1) r_state <= S_CSUM;
          end
        end
        S_CSUM: if (w_acc) begin
          if (i_in_data == r_sum) begin
            r_state    <= S_RUN;
            r_done     <= 1'b1;
            r_cpu_hold <= 1'b0;
          end else begin
            r_state    <= S_ERROR;
            r_err      <= 1'b1;
            r_cpu_hold <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_prog_loader.sv
// tb/tb_sap_prog_loader.sv - self-checking bench for sap_prog_loader
module tb_sap_prog_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: DATA_W=16, ADDR_W=8, clear enabled
  logic        rst16, v16, ready16, we16, hold16, done16, err16;
  logic [7:0]  d16, addr16;
  logic [15:0] wd16;
  // DUT B: DATA_W=32, ADDR_W=4, clear enabled
  logic        rst32, v32, ready32, we32, hold32, done32, err32;
  logic [7:0]  d32;
  logic [3:0]  addr32;
  logic [31:0] wd32;

  int total = 0;
  int bad   = 0;

  logic [23:0] sb[$];
  logic [35:0] wr32[$];
  logic [23:0] mon_exp;

  sap_prog_loader #(.DATA_W(16), .ADDR_W(8), .CLEAR_ON_RESET(1), .SYNC_BYTE(8'hA5)) dut16 (
    .i_clk(clk), .i_rst(rst16), .i_in_data(d16), .i_in_valid(v16), .o_in_ready(ready16),
    .o_mem_we(we16), .o_mem_addr(addr16), .o_mem_wdata(wd16),
    .o_cpu_hold(hold16), .o_done(done16), .o_err(err16)
  );

  sap_prog_loader #(.DATA_W(32), .ADDR_W(4), .CLEAR_ON_RESET(1), .SYNC_BYTE(8'hA5)) dut32 (
    .i_clk(clk), .i_rst(rst32), .i_in_data(d32), .i_in_valid(v32), .o_in_ready(ready32),
    .o_mem_we(we32), .o_mem_addr(addr32), .o_mem_wdata(wd32),
    .o_cpu_hold(hold32), .o_done(done32), .o_err(err32)
  );

  // Scoreboard for DUT A: every write must match the next expected entry
  always @(negedge clk) begin
    if (we16 === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got addr=%h data=%h required no write", addr16, wd16);
      end else begin
        mon_exp = sb.pop_front();
        if ({addr16, wd16} !== mon_exp) begin
          bad++;
          $display("FAIL write got addr=%h data=%h required addr=%h data=%h",
                   addr16, wd16, mon_exp[23:16], mon_exp[15:0]);
        end
      end
    end
  end

  // Write capture for DUT B
  always @(negedge clk) begin
    if (we32 === 1'b1) wr32.push_back({addr32, wd32});
  end

  task automatic send_byte(input int u, input logic [7:0] b);
    int n = 0;
    if (u == 0) begin v16 = 1'b1; d16 = b; end
    else        begin v32 = 1'b1; d32 = b; end
    while (((u == 0) ? ready16 : ready32) !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      total++; bad++;
      $display("FAIL send_timeout got in_ready=0 required in_ready=1 within 2000 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int u, input logic [7:0] f[$]);
    foreach (f[i]) send_byte(u, f[i]);
    if (u == 0) v16 = 1'b0; else v32 = 1'b0;
  endtask

  task automatic build_frame(input logic [15:0] a, input logic [15:0] w[$], input bit corrupt,
                             output logic [7:0] f[$]);
    logic [7:0] s;
    logic [7:0] aa;
    int n;
    n = w.size();
    f = {};
    f.push_back(8'hA5);
    f.push_back(a[15:8]);
    f.push_back(a[7:0]);
    f.push_back(8'(n >> 8));
    f.push_back(8'(n));
    aa = a[7:0];
    foreach (w[i]) begin
      f.push_back(w[i][15:8]);
      f.push_back(w[i][7:0]);
      sb.push_back({aa, w[i]});
      aa = aa + 8'd1;
    end
    s = 8'd0;
    for (int i = 1; i < f.size(); i++) s = s + f[i];
    f.push_back(corrupt ? s + 8'd1 : s);
  endtask

  task automatic wait_ready(input int u, input string name);
    int n = 0;
    while (((u == 0) ? ready16 : ready32) !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 1000) begin
      bad++;
      $display("FAIL %s got in_ready=0 required in_ready=1 within 1000 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst16 = 1'b0; rst32 = 1'b0;
    v16 = 1'b0; v32 = 1'b0; d16 = 8'h00; d32 = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if ({ready16, we16, hold16, done16, err16, addr16, wd16} !== {5'b00100, 8'h00, 16'h0000}) begin
      bad++;
      $display("FAIL reset_values got rdy/we/hold/done/err=%b%b%b%b%b required 00100",
               ready16, we16, hold16, done16, err16);
    end
    for (int i = 0; i < 256; i++) sb.push_back({8'(i), 16'h0000});
    @(posedge clk); #1;
    rst16 = 1'b1;
    wait_ready(0, "clear_end");
    repeat (2) @(posedge clk); #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL clear_count got %0d outstanding writes required 0", sb.size());
    end
    total++;
    if ({ready16, hold16, done16, err16} !== 4'b1100) begin
      bad++;
      $display("FAIL after_clear got rdy/hold/done/err=%b%b%b%b required 1100",
               ready16, hold16, done16, err16);
    end
  endtask

  task automatic test_frame_ok();
    logic [7:0] f[$];
    f = '{8'hA5, 8'h00, 8'h0A, 8'h00, 8'h02, 8'h0B, 8'h00, 8'h02, 8'h01, 8'h1A};
    sb.push_back({8'h0A, 16'h0B00});
    sb.push_back({8'h0B, 16'h0201});
    send_frame(0, f);
    total++;
    if ({done16, err16, hold16} !== 3'b100) begin
      bad++;
      $display("FAIL frame_ok_status got done/err/hold=%b%b%b required 100", done16, err16, hold16);
    end
    repeat (2) @(posedge clk); #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL frame_ok_writes got %0d outstanding required 0", sb.size());
    end
  endtask

  task automatic test_frame_bad();
    logic [7:0] f[$];
    f = '{8'hA5, 8'h00, 8'h0A, 8'h00, 8'h02, 8'h0B, 8'h00, 8'h02, 8'h01, 8'h1B};
    sb.push_back({8'h0A, 16'h0B00});
    sb.push_back({8'h0B, 16'h0201});
    send_frame(0, f);
    total++;
    if ({done16, err16, hold16} !== 3'b011) begin
      bad++;
      $display("FAIL frame_bad_status got done/err/hold=%b%b%b required 011", done16, err16, hold16);
    end
    repeat (2) @(posedge clk); #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL frame_bad_writes got %0d outstanding required 0", sb.size());
    end
    // SYNC after an error clears err on the next cycle
    send_byte(0, 8'hA5);
    total++;
    if ({err16, hold16} !== 2'b01) begin
      bad++;
      $display("FAIL sync_clears_err got err/hold=%b%b required 01", err16, hold16);
    end
    f = '{8'h00, 8'h0A, 8'h00, 8'h02, 8'h0B, 8'h00, 8'h02, 8'h01, 8'h1A};
    sb.push_back({8'h0A, 16'h0B00});
    sb.push_back({8'h0B, 16'h0201});
    send_frame(0, f);
    total++;
    if ({done16, err16, hold16} !== 3'b100) begin
      bad++;
      $display("FAIL recover_status got done/err/hold=%b%b%b required 100", done16, err16, hold16);
    end
  endtask

  task automatic test_wrap();
    logic [7:0]  f[$];
    logic [15:0] w[$];
    w = '{16'h1234, 16'h5678};
    build_frame(16'h00FF, w, 1'b0, f);
    send_frame(0, f);
    repeat (2) @(posedge clk); #1;
    total++;
    if (sb.size() != 0 || done16 !== 1'b1) begin
      bad++;
      $display("FAIL wrap got outstanding=%0d done=%b required 0 and 1", sb.size(), done16);
    end
  endtask

  task automatic test_count0();
    logic [7:0] f[$];
    f = '{8'hA5, 8'h00, 8'h05, 8'h00, 8'h00, 8'h05};
    send_frame(0, f);
    total++;
    if ({done16, err16, hold16} !== 3'b100) begin
      bad++;
      $display("FAIL count0 got done/err/hold=%b%b%b required 100", done16, err16, hold16);
    end
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  f[$];
    logic [7:0]  f2[$];
    logic [15:0] w[$];
    longint      t0;
    longint      cyc;
    w = '{16'hA55A};
    build_frame(16'h1234, w, 1'b0, f);
    w = '{16'($urandom), 16'($urandom), 16'($urandom)};
    build_frame(16'h0020, w, 1'b0, f2);
    f = {8'h00, 8'hFF, 8'h13, f, f2};
    t0 = $time;
    foreach (f[i]) send_byte(0, f[i]);
    cyc = ($time - t0) / 10;
    v16 = 1'b0;
    total++;
    if (cyc != longint'(f.size())) begin
      bad++;
      $display("FAIL full_rate got %0d cycles required %0d", cyc, f.size());
    end
    repeat (2) @(posedge clk); #1;
    total++;
    if (sb.size() != 0 || done16 !== 1'b1 || hold16 !== 1'b0) begin
      bad++;
      $display("FAIL back_to_back got outstanding=%0d done=%b hold=%b required 0,1,0",
               sb.size(), done16, hold16);
    end
  endtask

  task automatic check_clear32(input string name);
    bit ok;
    total++;
    if (wr32.size() != 16) begin
      bad++;
      $display("FAIL %s_count got %0d writes required 16", name, wr32.size());
    end
    ok = 1'b1;
    foreach (wr32[i]) if (wr32[i] !== {4'(i), 32'h0}) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_content got first=%h required ascending zero writes", name, wr32[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] f[$];
    wr32.delete();
    @(posedge clk); #1;
    rst32 = 1'b1;
    wait_ready(1, "clear32_end");
    repeat (2) @(posedge clk); #1;
    check_clear32("clear32");
    wr32.delete();
    f = '{8'hA5, 8'h00, 8'h03, 8'h00, 8'h01, 8'h11, 8'h22};
    foreach (f[i]) send_byte(1, f[i]);
    rst32 = 1'b0;
    v32 = 1'b0;
    #1;
    total++;
    if ({ready32, we32, hold32, done32, err32, addr32, wd32} !== {5'b00100, 4'h0, 32'h0}) begin
      bad++;
      $display("FAIL midreset_values got rdy/we/hold/done/err=%b%b%b%b%b required 00100",
               ready32, we32, hold32, done32, err32);
    end
    repeat (3) @(posedge clk); #1;
    total++;
    if (wr32.size() != 0) begin
      bad++;
      $display("FAIL midreset_partial got %0d writes required 0", wr32.size());
    end
    rst32 = 1'b1;
    wait_ready(1, "reclear32_end");
    repeat (2) @(posedge clk); #1;
    check_clear32("reclear32");
    wr32.delete();
    f = '{8'hA5, 8'h00, 8'h03, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAE};
    send_frame(1, f);
    repeat (2) @(posedge clk); #1;
    total++;
    if (wr32.size() != 1 || wr32[0] !== {4'h3, 32'h11223344} || done32 !== 1'b1 || hold32 !== 1'b0) begin
      bad++;
      $display("FAIL word32 got n=%0d first=%h done=%b hold=%b required 1, 311223344, 1, 0",
               wr32.size(), (wr32.size() > 0) ? wr32[0] : 36'h0, done32, hold32);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish required finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame_ok();
    test_frame_bad();
    test_wrap();
    test_count0();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk); #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got %0d outstanding required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sap_prog_loader.md
# sap_prog_loader

Parametrised program/data loader for the SAP computer. It receives a framed byte stream (valid/ready) and writes words into the SAP RAM write port, optionally clearing RAM first. It holds the CPU in reset until a frame passes its checksum, which replaces hierarchical RAM preloading with a synthesizable boot path. It sits between a byte source (UART RX or bench driver) and the RAM write port, and its `cpu_hold` output drives the SAP core reset.

## Interface
- `DATA_W`, 16, RAM word width; multiple of 8, 8..64.
- `ADDR_W`, 8, RAM address width; 1..16.
- `CLEAR_ON_RESET`, 1, when 1, zero all 2^ADDR_W words after reset before accepting bytes.
- `SYNC_BYTE`, 8'hA5, frame start marker.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_data` input 8: stream byte.
- `in_valid` input 1: byte present.
- `in_ready` output 1: byte accepted when `in_valid && in_ready`.
- `mem_we` output 1: one-cycle RAM write strobe.
- `mem_addr` output ADDR_W: write address.
- `mem_wdata` output DATA_W: write data.
- `cpu_hold` output 1: high holds the SAP core in reset.
- `done` output 1: last frame loaded and checksum-verified.
- `err` output 1: last frame failed its checksum (sticky).

## Operation
- Frame: SYNC, ADDR_H, ADDR_L, CNT_H, CNT_L, CNT×(DATA_W/8) data bytes MSB-first, CSUM.
- The 16-bit address and count fields are big-endian. The address uses its low ADDR_W bits; upper bits are ignored.
- CSUM must equal the mod-256 sum of every byte from ADDR_H through the last data byte.
- States: CLEAR, IDLE, ADDR_H, ADDR_L, CNT_H, CNT_L, DATA, CSUM, RUN, ERROR.
- CLEAR: `in_ready`=0. Writes 0 to addresses 0..2^ADDR_W−1, one per cycle, then goes to IDLE.
- IDLE, RUN, ERROR: `in_ready`=1. Non-SYNC bytes are accepted and dropped. A SYNC byte goes to ADDR_H, clears `done`/`err`, sets `cpu_hold`=1, and resets the running sum.
- Header states advance one state per accepted byte. CNT_L goes to DATA, or to CSUM when count=0.
- DATA: shifts bytes into the word register. On the last byte of a word, issues a write, then increments the address and decrements the remaining count. After the last word, goes to CSUM.
- CSUM match: go to RUN with `done`=1 and `cpu_hold`=0. Mismatch: go to ERROR with `err`=1 and `cpu_hold`=1.
- Address wraps modulo 2^ADDR_W. Writes already issued are never rolled back on checksum failure.
- A SYNC byte received mid-frame is treated as data, not as a restart.

## Timing
- Reset values: state=CLEAR if CLEAR_ON_RESET else IDLE. `cpu_hold`=1, all other outputs 0.
- `in_ready` is registered. It rises the cycle after CLEAR ends, and is 0 for the whole of reset.
- CLEAR: 2^ADDR_W consecutive `mem_we` cycles, addresses ascending from 0.
- Data write latency: `mem_we`, `mem_addr` and `mem_wdata` are registered and valid in the cycle after the last byte of a word is accepted. At most one write per cycle.
- `done`, `err` and `cpu_hold` update in the cycle after the CSUM byte is accepted.
- A full byte rate (`in_valid` held high) is sustained with no bubbles.
- `rst` asserted mid-frame aborts immediately to the reset values. After release, CLEAR repeats if enabled.

## Structure
- Package `sap_loader_pkg` holds:
  - the state enum;
  - the default SYNC_BYTE value;
  - the header-length constant (4 bytes).
- Sub-module `sap_word_packer`, parametrised by DATA_W:
  - byte shift register and byte-index counter;
  - `word_valid` pulse on the last byte.
- The top level holds the FSM, address/count counters, checksum accumulator and clear counter.

## Test plan
- Reset with CLEAR_ON_RESET=1, ADDR_W=8 -> 256 writes of 0x0000 to addresses 0..255; `in_ready` then 1; `cpu_hold`=1.
- Frame A5 00 0A 00 02 0B 00 02 01 1A -> writes mem[10]=0x0B00 and mem[11]=0x0201; then `done`=1 and `cpu_hold`=0.
- Same frame with CSUM 1B -> both writes still issued; then `err`=1, `done`=0, `cpu_hold`=1. A following valid frame clears `err`.
- Frame with addr 0x00FF and count 2 (ADDR_W=8) -> writes to addresses 0xFF and then 0x00 (wrap).
- Count 0 frame A5 00 05 00 00 05 -> no writes; `done`=1.
- `rst` low during the DATA state, with DATA_W=32 -> no partial write; outputs return to reset values; CLEAR reruns.
